// File: rtl/adam_periph_uart_pkg.sv
// adam_periph_uart_pkg: shared FSM states, status bit indices and config clamps for the UART receiver
package adam_periph_uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_e;
  localparam int STATUS_PARITY = 0;
  localparam int STATUS_FRAME = 1;
  localparam int STATUS_OVERRUN = 2;
  localparam int STATUS_BREAK = 3;
  function automatic logic [3:0] clamp_length(input logic [3:0] len);
    return (len < 4'd5) ? 4'd5 : (len > 4'd9) ? 4'd9 : len;
  endfunction
  function automatic logic [63:0] clamp_baud(input logic [63:0] baud);
    return (baud < 64'd8) ? 64'd8 : baud;
  endfunction
endpackage

// File: rtl/adam_periph_uart_rx_fifo_buf.sv
// adam_periph_uart_rx_fifo_buf: synchronous FIFO with stream master output and occupancy level
module adam_periph_uart_rx_fifo_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int AW = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  hold,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] mst_data,
  output logic                  mst_valid,
  input  logic                  mst_ready,
  output logic [AW:0]           level
);
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic empty, pop, wr_en;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign mst_valid = !empty && !hold;
  assign pop = mst_valid && mst_ready;
  assign wr_en = push && (!full || pop);
  assign mst_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign level = wr_ptr - rd_ptr;
  // storage write; contents need no reset since empty masks the output
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end
  // pointer advance; extra MSB distinguishes full from empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/adam_periph_uart_rx_fifo.sv
// adam_periph_uart_rx_fifo: majority-vote UART receiver with error tagging, break detection and an output FIFO
module adam_periph_uart_rx_fifo
  import adam_periph_uart_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pause_req,
  output logic                          pause_ack,
  input  logic                          parity_select,
  input  logic                          parity_control,
  input  logic [3:0]                    data_length,
  input  logic [1:0]                    stop_bits,
  input  logic [DATA_WIDTH-1:0]         baud_rate,
  input  logic                          err_clr,
  output logic [3:0]                    status,
  output logic [7:0]                    overrun_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [DATA_WIDTH-1:0]         mst_data,
  output logic                          mst_valid,
  input  logic                          mst_ready,
  input  logic                          rx
);
  state_e state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic rx_s, rx_prev_q, fall, cfg_start, in_bit, vote, bit_end, maj, brk, done, full, overrun;
  logic [DATA_WIDTH-1:0] cnt_q, baud_q, half;
  logic [3:0] len_q, bit_q;
  logic [1:0] stop_q, stop_idx_q;
  logic par_en_q, par_sel_q, zero_q, pe_q, fe_q, v0_q, v1_q, push_q;
  logic [8:0] data_q;
  logic [10:0] push_word_q;
  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = rx_prev_q && !rx_s;
  assign cfg_start = state_q == IDLE && fall && !pause_req && !pause_ack;
  assign in_bit = state_q inside {START, DATA, PARITY, STOP};
  assign half = baud_q >> 1;
  assign vote = in_bit && cnt_q == half + 1'b1;
  assign bit_end = in_bit && cnt_q == baud_q - 1'b1;
  assign maj = (v0_q && v1_q) || (v0_q && rx_s) || (v1_q && rx_s);
  assign brk = state_q == STOP && vote && stop_idx_q == 2'd0 && zero_q && !maj;
  assign done = state_q == STOP && vote && stop_idx_q == stop_q && !brk;
  assign overrun = push_q && full && !(mst_valid && mst_ready);
  // rx synchroniser and edge history, idling high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_prev_q <= rx_s;
    end
  end
  // frame state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // frame sequencing from votes and bit boundaries
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = cfg_start ? START : IDLE;
      START:   state_d = (vote && maj) ? IDLE : bit_end ? DATA : START;
      DATA:    state_d = (bit_end && bit_q == len_q - 4'd1) ? (par_en_q ? PARITY : STOP) : DATA;
      PARITY:  state_d = bit_end ? STOP : PARITY;
      STOP:    state_d = brk ? BREAK : done ? IDLE : STOP;
      BREAK:   state_d = rx_s ? IDLE : BREAK;
      default: state_d = IDLE;
    endcase
  end
  // bit timer, config latch, sampling and frame assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      baud_q <= DATA_WIDTH'(8);
      len_q <= 4'd8;
      stop_q <= '0;
      par_en_q <= 1'b0;
      par_sel_q <= 1'b0;
      bit_q <= '0;
      stop_idx_q <= '0;
      data_q <= '0;
      zero_q <= 1'b0;
      pe_q <= 1'b0;
      fe_q <= 1'b0;
      v0_q <= 1'b1;
      v1_q <= 1'b1;
      push_q <= 1'b0;
      push_word_q <= '0;
    end else begin
      cnt_q <= (!in_bit || state_d != state_q || bit_end) ? '0 : cnt_q + 1'b1;
      if (in_bit && cnt_q == half - 1'b1) v0_q <= rx_s;
      if (in_bit && cnt_q == half) v1_q <= rx_s;
      if (cfg_start) begin
        baud_q <= DATA_WIDTH'(clamp_baud(64'(baud_rate)));
        len_q <= clamp_length(data_length);
        stop_q <= stop_bits;
        par_en_q <= parity_control;
        par_sel_q <= parity_select;
        bit_q <= '0;
        stop_idx_q <= '0;
        data_q <= '0;
        zero_q <= 1'b1;
        pe_q <= 1'b0;
        fe_q <= 1'b0;
      end
      if (state_q == DATA && vote) begin
        data_q[bit_q] <= maj;
        zero_q <= zero_q && !maj;
      end
      if (state_q == DATA && bit_end) bit_q <= bit_q + 4'd1;
      if (state_q == PARITY && vote) begin
        pe_q <= maj ^ (^data_q) ^ par_sel_q;
        zero_q <= zero_q && !maj;
      end
      if (state_q == STOP && vote) fe_q <= fe_q || !maj;
      if (state_q == STOP && bit_end) stop_idx_q <= stop_idx_q + 2'd1;
      push_q <= done;
      if (done) push_word_q <= {fe_q || !maj, pe_q, data_q};
    end
  end
  // sticky status and saturating overrun count; clear wins over a same-cycle set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status <= '0;
      overrun_cnt <= '0;
    end else if (err_clr) begin
      status <= '0;
      overrun_cnt <= '0;
    end else begin
      if (push_q) begin
        status[STATUS_PARITY] <= status[STATUS_PARITY] || push_word_q[9];
        status[STATUS_FRAME] <= status[STATUS_FRAME] || push_word_q[10];
      end
      if (overrun) begin
        status[STATUS_OVERRUN] <= 1'b1;
        overrun_cnt <= (overrun_cnt == 8'hff) ? overrun_cnt : overrun_cnt + 8'd1;
      end
      if (brk) status[STATUS_BREAK] <= 1'b1;
    end
  end
  // pause acknowledged only between frames, released one cycle after request drops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pause_ack <= 1'b0;
    else pause_ack <= pause_req && (pause_ack || state_q == IDLE);
  end
  adam_periph_uart_rx_fifo_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data ({{(DATA_WIDTH-11){1'b0}}, push_word_q}),
    .hold      (pause_ack),
    .full      (full),
    .mst_data  (mst_data),
    .mst_valid (mst_valid),
    .mst_ready (mst_ready),
    .level     (fifo_level)
  );
endmodule

// File: tb/tb_adam_periph_uart_rx_fifo.sv
// tb_adam_periph_uart_rx_fifo: directed frame vectors plus corner-case sequences for the buffered UART receiver
module tb_adam_periph_uart_rx_fifo;
  localparam int BAUD = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic pause_req = 1'b0, pause_ack;
  logic parity_select = 1'b0, parity_control = 1'b1;
  logic [3:0] data_length = 4'd8;
  logic [1:0] stop_bits = 2'd1;
  logic [31:0] baud_rate = BAUD;
  logic err_clr = 1'b0;
  logic [3:0] status;
  logic [7:0] overrun_cnt;
  logic [3:0] fifo_level;
  logic [31:0] mst_data;
  logic mst_valid, mst_ready = 1'b1;
  logic rx = 1'b1;
  int checks = 0, errors = 0;
  logic [31:0] q[$];

  typedef struct {
    logic [3:0]  len_cfg;
    int          nbits;
    bit          pen;
    bit          psel;
    bit          flip;
    logic [1:0]  stop;
    bit          last_stop;
    logic [8:0]  d;
    logic [31:0] exp_word;
    logic [3:0]  exp_status;
  } vec_t;
  vec_t vecs[8];

  adam_periph_uart_rx_fifo dut (
    .clk(clk), .rst(rst), .pause_req(pause_req), .pause_ack(pause_ack),
    .parity_select(parity_select), .parity_control(parity_control),
    .data_length(data_length), .stop_bits(stop_bits), .baud_rate(baud_rate),
    .err_clr(err_clr), .status(status), .overrun_cnt(overrun_cnt),
    .fifo_level(fifo_level), .mst_data(mst_data), .mst_valid(mst_valid),
    .mst_ready(mst_ready), .rx(rx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mst_valid && mst_ready) q.push_back(mst_data);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic get_word(input string name, input logic [31:0] exp);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no word expected %h", name, exp);
    end else chk(name, q.pop_front(), exp);
  endtask

  function automatic bit par(input logic [8:0] d, input int n);
    bit p = 1'b0;
    for (int i = 0; i < n; i++) p ^= d[i];
    return p;
  endfunction

  task automatic send_frame(input logic [8:0] d, input int nbits, input bit pen, input bit pbit,
                            input int nstop, input bit last_stop);
    rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx = d[i];
      repeat (BAUD) @(negedge clk);
    end
    if (pen) begin
      rx = pbit;
      repeat (BAUD) @(negedge clk);
    end
    for (int i = 0; i < nstop; i++) begin
      rx = (i == nstop - 1) ? last_stop : 1'b1;
      repeat (BAUD) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_std(input logic [8:0] d);
    send_frame(d, 8, 1'b1, par(d, 8), 2, 1'b1);
  endtask

  initial begin
    vecs[0] = '{4'd8,  8, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 9'h03C, 32'h03C, 4'h0};
    vecs[1] = '{4'd8,  8, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 9'h0A5, 32'h2A5, 4'h1};
    vecs[2] = '{4'd5,  5, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 9'h015, 32'h015, 4'h0};
    vecs[3] = '{4'd9,  9, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 9'h1FF, 32'h1FF, 4'h0};
    vecs[4] = '{4'd3,  5, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 9'h00B, 32'h00B, 4'h0};
    vecs[5] = '{4'd15, 9, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 9'h155, 32'h155, 4'h0};
    vecs[6] = '{4'd8,  8, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 9'h081, 32'h481, 4'h2};
    vecs[7] = '{4'd8,  8, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 9'h05A, 32'h45A, 4'h2};

    repeat (3) @(negedge clk);
    chk("reset_valid", 32'(mst_valid), 0);
    chk("reset_data", mst_data, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_status", 32'(status), 0);
    chk("reset_overrun_cnt", 32'(overrun_cnt), 0);
    chk("reset_level", 32'(fifo_level), 0);
    chk("reset_pause_ack", 32'(pause_ack), 0);

    foreach (vecs[i]) begin
      data_length = vecs[i].len_cfg;
      parity_control = vecs[i].pen;
      parity_select = vecs[i].psel;
      stop_bits = vecs[i].stop;
      send_frame(vecs[i].d, vecs[i].nbits, vecs[i].pen,
                 par(vecs[i].d, vecs[i].nbits) ^ vecs[i].psel ^ vecs[i].flip,
                 int'(vecs[i].stop) + 1, vecs[i].last_stop);
      repeat (6) @(negedge clk);
      get_word($sformatf("vec%0d_word", i), vecs[i].exp_word);
      chk($sformatf("vec%0d_status", i), 32'(status), 32'(vecs[i].exp_status));
      clear_errs();
      chk($sformatf("vec%0d_cleared", i), 32'(status), 0);
    end

    data_length = 4'd8;
    parity_control = 1'b1;
    parity_select = 1'b0;
    stop_bits = 2'd1;
    for (int v = 0; v < 256; v++) send_std(9'(v));
    repeat (8) @(negedge clk);
    for (int v = 0; v < 256; v++) get_word($sformatf("stream_%0d", v), 32'(v));
    chk("stream_status", 32'(status), 0);

    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BAUD) @(negedge clk);
    chk("false_start_queue", q.size(), 0);
    chk("false_start_level", 32'(fifo_level), 0);
    chk("false_start_status", 32'(status), 0);

    rx = 1'b0;
    repeat (12 * BAUD) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BAUD) @(negedge clk);
    chk("break_queue", q.size(), 0);
    chk("break_status", 32'(status), 32'h8);
    clear_errs();
    send_std(9'h055);
    repeat (6) @(negedge clk);
    get_word("after_break_word", 32'h055);
    chk("after_break_status", 32'(status), 0);

    mst_ready = 1'b0;
    for (int v = 0; v < 10; v++) send_std(9'(v));
    repeat (8) @(negedge clk);
    chk("overrun_level", 32'(fifo_level), 8);
    chk("overrun_cnt", 32'(overrun_cnt), 2);
    chk("overrun_status", 32'(status), 32'h4);
    chk("overrun_head_held", mst_data, 0);
    mst_ready = 1'b1;
    repeat (12) @(negedge clk);
    for (int v = 0; v < 8; v++) get_word($sformatf("drain_%0d", v), 32'(v));
    chk("drain_extra", q.size(), 0);
    chk("drain_level", 32'(fifo_level), 0);
    clear_errs();
    chk("overrun_cnt_cleared", 32'(overrun_cnt), 0);

    fork
      send_std(9'h03C);
      begin
        repeat (4 * BAUD) @(negedge clk);
        pause_req = 1'b1;
        repeat (2) @(negedge clk);
        chk("pause_ack_midframe", 32'(pause_ack), 0);
      end
    join
    repeat (4) @(negedge clk);
    chk("pause_ack_idle", 32'(pause_ack), 1);
    chk("pause_valid_forced", 32'(mst_valid), 0);
    chk("pause_level", 32'(fifo_level), 1);
    send_std(9'h077);
    repeat (4) @(negedge clk);
    chk("pause_ignored_level", 32'(fifo_level), 1);
    chk("pause_ignored_queue", q.size(), 0);
    pause_req = 1'b0;
    @(negedge clk);
    chk("pause_ack_release", 32'(pause_ack), 0);
    repeat (4) @(negedge clk);
    get_word("pause_word", 32'h03C);
    chk("pause_no_extra", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
